// File: rtl/nor_logic_unit_if.sv
// ============================================================================
//  Module      : nor_logic_unit_if
//  Description : Operand/result stream bundle for nor_logic_unit.
//                The master drives operands and consumes results.
//                The slave is the logic unit itself.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface nor_logic_unit_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, y
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, y
   );
endinterface

`default_nettype wire

// File: rtl/nor_logic_unit.sv
// ============================================================================
//  Module      : nor_logic_unit
//  Description : Registered WIDTH-bit logic unit with eight bitwise ops, every
//                one built only from 2-input NOR gates. It has a valid/ready
//                stream with a one-deep output register. A built-in self-test
//                sweeps all op/operand combinations through the same NOR
//                network and checks them against a golden truth table.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module nor_logic_unit #(
   parameter int WIDTH = 8
) (
   input  wire logic           clk,
   input  wire logic           rst,
   nor_logic_unit_if.slave     bus,
   input  wire logic           bist_start,
   input  wire logic           bist_inject,
   output logic                bist_busy,
   output logic                bist_done,
   output logic                bist_pass
);

   // Op encoding
   localparam logic [2:0] c_OP_OR   = 3'd0;
   localparam logic [2:0] c_OP_NOR  = 3'd1;
   localparam logic [2:0] c_OP_AND  = 3'd2;
   localparam logic [2:0] c_OP_NAND = 3'd3;
   localparam logic [2:0] c_OP_XOR  = 3'd4;
   localparam logic [2:0] c_OP_XNOR = 3'd5;
   localparam logic [2:0] c_OP_NOTA = 3'd6;
   localparam logic [2:0] c_OP_BUFA = 3'd7;

   // Golden truth table indexed by the BIST vector {op, a, b}.
   // Each nibble is one op, bit index {a,b}; op 7 in the top nibble.
   localparam logic [31:0] c_GOLDEN = 32'hC396_781E;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [4:0]       r_vec;
   logic             r_fail;
   logic             r_pass;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_y;

   logic             w_run;
   logic [2:0]       w_op;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;

   // NOR network nodes, one bit per lane
   logic [WIDTH-1:0] w_nor;
   logic [WIDTH-1:0] w_or;
   logic [WIDTH-1:0] w_na;
   logic [WIDTH-1:0] w_nb;
   logic [WIDTH-1:0] w_and;
   logic [WIDTH-1:0] w_nand;
   logic [WIDTH-1:0] w_x2;
   logic [WIDTH-1:0] w_x3;
   logic [WIDTH-1:0] w_xnor;
   logic [WIDTH-1:0] w_xor;
   logic [WIDTH-1:0] w_buf;

   logic [WIDTH-1:0] w_net_y;
   logic [WIDTH-1:0] w_inj_mask;
   logic [WIDTH-1:0] w_gold;
   logic             w_mismatch;
   logic             w_in_ready;
   logic             w_xfer;

   // The one primitive every lane is built from
   function automatic logic f_nor2(input logic x, input logic z);
      return ~(x | z);
   endfunction

   // During RUN the network is driven by the self-test vector, otherwise by the bus
   assign w_run = (r_state == S_RUN);
   assign w_op  = w_run ? r_vec[4:2]        : bus.op;
   assign w_a   = w_run ? {WIDTH{r_vec[1]}} : bus.a;
   assign w_b   = w_run ? {WIDTH{r_vec[0]}} : bus.b;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_lane
         assign w_nor[i]  = f_nor2(w_a[i],   w_b[i]);
         assign w_or[i]   = f_nor2(w_nor[i], w_nor[i]);
         assign w_na[i]   = f_nor2(w_a[i],   w_a[i]);
         assign w_nb[i]   = f_nor2(w_b[i],   w_b[i]);
         assign w_and[i]  = f_nor2(w_na[i],  w_nb[i]);
         assign w_nand[i] = f_nor2(w_and[i], w_and[i]);
         // x2 = ~a & b, x3 = a & ~b; their NOR is XNOR
         assign w_x2[i]   = f_nor2(w_a[i],   w_nor[i]);
         assign w_x3[i]   = f_nor2(w_b[i],   w_nor[i]);
         assign w_xnor[i] = f_nor2(w_x2[i],  w_x3[i]);
         assign w_xor[i]  = f_nor2(w_xnor[i], w_xnor[i]);
         assign w_buf[i]  = f_nor2(w_na[i],  w_na[i]);
      end
   endgenerate

   // Op select among the NOR-network outputs
   always_comb begin
      w_net_y = '0;
      case (w_op)
         c_OP_OR:   w_net_y = w_or;
         c_OP_NOR:  w_net_y = w_nor;
         c_OP_AND:  w_net_y = w_and;
         c_OP_NAND: w_net_y = w_nand;
         c_OP_XOR:  w_net_y = w_xor;
         c_OP_XNOR: w_net_y = w_xnor;
         c_OP_NOTA: w_net_y = w_na;
         c_OP_BUFA: w_net_y = w_buf;
         default:   w_net_y = '0;
      endcase
   end

   // Self-test compare: optional bit-0 fault injection, then check all lanes
   always_comb begin
      w_inj_mask    = '0;
      w_inj_mask[0] = bist_inject;
   end

   assign w_gold     = {WIDTH{c_GOLDEN[r_vec]}};
   assign w_mismatch = ((w_net_y ^ w_inj_mask) != w_gold);

   // Handshake
   assign w_in_ready    = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
   assign w_xfer        = bus.in_valid && w_in_ready;
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.y         = r_y;

   assign bist_busy = (r_state != S_IDLE);
   assign bist_done = (r_state == S_DONE);
   assign bist_pass = r_pass;

   // Self-test FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bist_start)   w_state_nxt = S_DRAIN;
         S_DRAIN: if (!r_out_valid) w_state_nxt = S_RUN;
         S_RUN:   if (r_vec == 5'd31) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Self-test FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Vector counter runs only while sweeping and restarts from zero each run
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vec <= '0;
      end else if (r_state == S_RUN) begin
         r_vec <= r_vec + 5'd1;
      end else begin
         r_vec <= '0;
      end
   end

   // Sticky fail flag and pass result, both cleared by an accepted start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fail <= 1'b0;
         r_pass <= 1'b0;
      end else begin
         if (r_state == S_IDLE && bist_start) begin
            r_fail <= 1'b0;
            r_pass <= 1'b0;
         end else if (r_state == S_RUN && w_mismatch) begin
            r_fail <= 1'b1;
         end else if (r_state == S_DONE) begin
            r_pass <= !r_fail;
         end
      end
   end

   // One-deep output register: load on transfer, drop valid on drain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y         <= '0;
         r_out_valid <= 1'b0;
      end else if (w_xfer) begin
         r_y         <= w_net_y;
         r_out_valid <= 1'b1;
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_nor_logic_unit.sv
// ============================================================================
//  Module      : tb_nor_logic_unit
//  Description : Directed self-checking bench for nor_logic_unit (WIDTH=8).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nor_logic_unit;

   logic clk;
   logic rst;
   logic bist_start;
   logic bist_inject;
   logic bist_busy;
   logic bist_done;
   logic bist_pass;

   int n_checks;
   int n_errors;

   nor_logic_unit_if #(.WIDTH(8)) bus ();

   nor_logic_unit #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .bist_start  (bist_start),
      .bist_inject (bist_inject),
      .bist_busy   (bist_busy),
      .bist_done   (bist_done),
      .bist_pass   (bist_pass)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = 8'h00; bus.b = 8'h00;
      bus.out_ready = 1'b0; bist_start = 1'b0; bist_inject = 1'b0;
      tick(); tick();
      n_checks++;
      if (bus.y !== 8'h00 || bus.out_valid !== 1'b0) begin
         n_errors++; $display("FAIL por_outputs: y=%h ov=%b expected y=00 ov=0", bus.y, bus.out_valid);
      end
      n_checks++;
      if (bist_busy !== 1'b0 || bist_done !== 1'b0 || bist_pass !== 1'b0) begin
         n_errors++; $display("FAIL por_bist: busy=%b done=%b pass=%b expected 000", bist_busy, bist_done, bist_pass);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_errors++; $display("FAIL por_in_ready: got %b expected 1", bus.in_ready);
      end
      // hold a result (XOR 0F^33 = 3C) then reset mid-stream
      bus.in_valid = 1'b1; bus.op = 3'd4; bus.a = 8'h0F; bus.b = 8'h33;
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.y !== 8'h3C) begin
         n_errors++; $display("FAIL pre_reset_hold: ov=%b y=%h expected ov=1 y=3C", bus.out_valid, bus.y);
      end
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (bus.y !== 8'h00 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bist_pass !== 1'b0) begin
         n_errors++;
         $display("FAIL midstream_reset: y=%h ov=%b ir=%b pass=%b expected y=00 ov=0 ir=1 pass=0",
                  bus.y, bus.out_valid, bus.in_ready, bist_pass);
      end
   endtask

   task automatic test_function_sweep();
      logic [7:0] exp_y [8];
      exp_y = '{8'hFC, 8'h03, 8'hC0, 8'h3F, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
      tick();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a = 8'hF0; bus.b = 8'hCC;
      for (int k = 0; k < 8; k++) begin
         bus.op = 3'(k);
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b1) begin
            n_errors++; $display("FAIL sweep_in_ready op%0d: got %b expected 1", k, bus.in_ready);
         end
         tick();
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.y !== exp_y[k]) begin
            n_errors++; $display("FAIL sweep_op%0d: ov=%b y=%h expected ov=1 y=%h", k, bus.out_valid, bus.y, exp_y[k]);
         end
      end
      bus.in_valid = 1'b0;
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.y !== 8'hF0) begin
         n_errors++; $display("FAIL sweep_drain: ov=%b y=%h expected ov=0 y=F0", bus.out_valid, bus.y);
      end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.op = 3'd4; bus.a = 8'hAA; bus.b = 8'h55;
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.y !== 8'hFF) begin
         n_errors++; $display("FAIL bp_first: ov=%b y=%h expected ov=1 y=FF", bus.out_valid, bus.y);
      end
      // next operand: AND FF & 0F = 0F, waiting on the consumer
      bus.op = 3'd2; bus.a = 8'hFF; bus.b = 8'h0F;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.y !== 8'hFF) begin
            n_errors++;
            $display("FAIL bp_hold%0d: ir=%b ov=%b y=%h expected ir=0 ov=1 y=FF", k, bus.in_ready, bus.out_valid, bus.y);
         end
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.y !== 8'h0F) begin
         n_errors++; $display("FAIL bp_next: ov=%b y=%h expected ov=1 y=0F", bus.out_valid, bus.y);
      end
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_errors++; $display("FAIL bp_drain: ov=%b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_bist_pass();
      int  n;
      bit  ov_seen;
      ov_seen = 1'b0;
      bist_inject = 1'b0;
      bist_start  = 1'b1;
      tick();
      bist_start = 1'b0;
      n = 1;
      n_checks++;
      if (bist_busy !== 1'b1 || bist_pass !== 1'b0) begin
         n_errors++; $display("FAIL bist_start_busy: busy=%b pass=%b expected busy=1 pass=0", bist_busy, bist_pass);
      end
      while (bist_done !== 1'b1 && n < 100) begin
         if (bus.out_valid !== 1'b0) ov_seen = 1'b1;
         tick();
         n++;
      end
      n_checks++;
      if (n != 34) begin
         n_errors++; $display("FAIL bist_latency: done at cycle %0d expected 34", n);
      end
      n_checks++;
      if (ov_seen) begin
         n_errors++; $display("FAIL bist_out_valid: out_valid seen 1 expected 0 throughout");
      end
      tick();
      n_checks++;
      if (bist_done !== 1'b0 || bist_busy !== 1'b0 || bist_pass !== 1'b1) begin
         n_errors++;
         $display("FAIL bist_pass_result: done=%b busy=%b pass=%b expected done=0 busy=0 pass=1", bist_done, bist_busy, bist_pass);
      end
      n_checks++;
      if (bus.y !== 8'h0F) begin
         n_errors++; $display("FAIL bist_y_held: y=%h expected 0F", bus.y);
      end
   endtask

   task automatic test_bist_fail_drain();
      int  n;
      bit  early_done;
      early_done = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.op = 3'd0; bus.a = 8'h01; bus.b = 8'h02;
      tick();
      bus.in_valid = 1'b0;
      bist_inject  = 1'b1;
      bist_start   = 1'b1;
      tick();
      bist_start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bist_start = (k == 2);
         if (bist_done === 1'b1) early_done = 1'b1;
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.y !== 8'h03 || bus.in_ready !== 1'b0 || bist_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_hold%0d: ov=%b y=%h ir=%b busy=%b expected ov=1 y=03 ir=0 busy=1",
                     k, bus.out_valid, bus.y, bus.in_ready, bist_busy);
         end
         tick();
      end
      bist_start = 1'b0;
      n_checks++;
      if (early_done) begin
         n_errors++; $display("FAIL drain_early_done: done=1 seen expected 0 while draining");
      end
      bus.out_ready = 1'b1;
      tick();
      n = 1;
      while (bist_done !== 1'b1 && n < 100) begin
         bist_start = (n == 10);
         tick();
         n++;
      end
      bist_start = 1'b0;
      n_checks++;
      if (n != 34) begin
         n_errors++; $display("FAIL drain_latency: done at cycle %0d after release expected 34", n);
      end
      tick();
      bist_inject = 1'b0;
      n_checks++;
      if (bist_pass !== 1'b0 || bist_busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.y !== 8'h03) begin
         n_errors++;
         $display("FAIL inject_result: pass=%b busy=%b ov=%b y=%h expected pass=0 busy=0 ov=0 y=03",
                  bist_pass, bist_busy, bus.out_valid, bus.y);
      end
   endtask

   task automatic test_reset_during_run();
      bit done_seen;
      done_seen = 1'b0;
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      for (int k = 0; k < 11; k++) tick();
      n_checks++;
      if (bist_busy !== 1'b1) begin
         n_errors++; $display("FAIL run_busy: busy=%b expected 1", bist_busy);
      end
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (bist_busy !== 1'b0 || bist_done !== 1'b0 || bist_pass !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL run_reset: busy=%b done=%b pass=%b ir=%b expected busy=0 done=0 pass=0 ir=1",
                  bist_busy, bist_done, bist_pass, bus.in_ready);
      end
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bist_done !== 1'b0 || bist_busy !== 1'b0) done_seen = 1'b1;
      end
      n_checks++;
      if (done_seen) begin
         n_errors++; $display("FAIL run_reset_no_done: activity seen after reset expected none");
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_function_sweep();
      test_backpressure();
      test_bist_pass();
      test_bist_fail_drain();
      test_reset_during_run();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
